// File: rtl/ss_ddram_pkg.sv
// Shared state encoding, half-select constants and qword helpers for the save-state DDR bridge.
package ss_ddram_pkg;

    localparam int SS_AW = 22;

    localparam logic HALF_LO = 1'b0;
    localparam logic HALF_HI = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_WAIT,
        RMW_RD,
        RMW_WAIT,
        RD_ISSUE,
        RD_WAIT,
        FLUSH_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_RD,
        OP_WR,
        OP_FL
    } op_t;

    function automatic int qword_aw(input int aw);
        return aw - 1;
    endfunction

    function automatic logic [63:0] merge_half(input logic [63:0] qword, input logic [31:0] data,
                                               input logic sel);
        logic [63:0] r;
        r = qword;
        if (sel == HALF_HI) r[63:32] = data;
        else                r[31:0]  = data;
        return r;
    endfunction

    function automatic logic [31:0] pick_half(input logic [63:0] qword, input logic sel);
        return (sel == HALF_LO) ? qword[31:0] : qword[63:32];
    endfunction

    function automatic logic [1:0] half_bit(input logic sel);
        return (sel == HALF_HI) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ss_ddram_bridge.sv
// 32-bit save-state bus to 64-bit ch4 bridge with one write-combining and one read qword buffer.
// Buffer hits ack after 1 cycle, misses after the ch4 round trip; busy holds off the core meanwhile.
module ss_ddram_bridge
    import ss_ddram_pkg::*;
#(
    parameter logic [27:0] BASE_ADDR = 28'h3C00000,
    parameter int          AW        = SS_AW
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic [AW-1:0] ss_addr,
    input  logic [31:0]   ss_din,
    input  logic          ss_rnw,
    input  logic          ss_req,
    output logic [31:0]   ss_dout,
    output logic          ss_ack,
    input  logic          ss_flush,
    output logic          busy,
    output logic [26:0]   ch4_addr,
    output logic [63:0]   ch4_din,
    input  logic [63:0]   ch4_dout,
    output logic          ch4_req,
    output logic          ch4_rnw,
    input  logic          ch4_ready
);

    localparam int QW = qword_aw(AW);

    state_t        state;
    op_t           op;
    logic [63:0]   wbuf, rbuf;
    logic [QW-1:0] wtag, rtag, op_q;
    logic [1:0]    wvalid;
    logic          rvalid;
    logic          op_h, op_done, flush_pend;
    logic [31:0]   op_din;

    logic [QW-1:0] req_q;
    logic          req_h;
    logic [1:0]    req_wv;
    logic          w_hit;

    assign req_q  = ss_addr[AW-1:1];
    assign req_h  = ss_addr[0];
    assign req_wv = wvalid | half_bit(req_h);
    assign w_hit  = (wvalid != 2'b00) && (wtag == req_q);

    function automatic logic [26:0] qaddr(input logic [QW-1:0] q);
        return 27'((BASE_ADDR + 28'({q, 3'b000})) >> 1);
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            op         <= OP_RD;
            wbuf       <= '0;
            rbuf       <= '0;
            wtag       <= '0;
            rtag       <= '0;
            op_q       <= '0;
            wvalid     <= 2'b00;
            rvalid     <= 1'b0;
            op_h       <= 1'b0;
            op_done    <= 1'b0;
            op_din     <= '0;
            flush_pend <= 1'b0;
            ss_dout    <= '0;
            ss_ack     <= 1'b0;
            busy       <= 1'b0;
            ch4_addr   <= '0;
            ch4_din    <= '0;
            ch4_req    <= 1'b0;
            ch4_rnw    <= 1'b0;
        end else begin
            ss_ack  <= 1'b0;
            ch4_req <= 1'b0;
            if (ss_flush) flush_pend <= 1'b1;
            case (state)
                IDLE: begin
                    if (ss_req && !busy) begin
                        op_q       <= req_q;
                        op_h       <= req_h;
                        op_din     <= ss_din;
                        flush_pend <= ss_flush;
                        if (!ss_rnw) begin
                            op <= OP_WR;
                            if (wvalid == 2'b00 || wtag == req_q) begin
                                wbuf   <= merge_half(wbuf, ss_din, req_h);
                                wtag   <= req_q;
                                wvalid <= req_wv;
                                if (rvalid && rtag == req_q) rbuf <= merge_half(rbuf, ss_din, req_h);
                                if (req_wv == 2'b11) begin
                                    op_done <= 1'b1;
                                    busy    <= 1'b1;
                                    state   <= WR_ISSUE;
                                end else begin
                                    ss_ack <= 1'b1;
                                    busy   <= ss_flush;
                                end
                            end else begin
                                // a different qword owns the buffer: commit it before merging
                                op_done <= 1'b0;
                                busy    <= 1'b1;
                                state   <= (wvalid == 2'b11) ? WR_ISSUE : RMW_RD;
                            end
                        end else begin
                            op <= OP_RD;
                            if (w_hit && wvalid[req_h]) begin
                                ss_dout <= pick_half(wbuf, req_h);
                                ss_ack  <= 1'b1;
                                busy    <= ss_flush;
                            end else if (w_hit) begin
                                busy  <= 1'b1;
                                state <= RMW_RD;
                            end else if (rvalid && rtag == req_q) begin
                                ss_dout <= pick_half(rbuf, req_h);
                                ss_ack  <= 1'b1;
                                busy    <= ss_flush;
                            end else begin
                                busy  <= 1'b1;
                                state <= RD_ISSUE;
                            end
                        end
                    end else if (ss_flush || flush_pend) begin
                        op         <= OP_FL;
                        flush_pend <= 1'b0;
                        if (wvalid == 2'b00) begin
                            ss_ack <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            busy  <= 1'b1;
                            state <= (wvalid == 2'b11) ? WR_ISSUE : RMW_RD;
                        end
                    end
                end
                WR_ISSUE: begin
                    ch4_req  <= 1'b1;
                    ch4_rnw  <= 1'b0;
                    ch4_addr <= qaddr(wtag);
                    ch4_din  <= wbuf;
                    state    <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (ch4_ready) begin
                        if (op == OP_FL) begin
                            wvalid <= 2'b00;
                            state  <= FLUSH_DONE;
                        end else if (op == OP_RD) begin
                            wvalid <= 2'b00;
                            state  <= RD_ISSUE;
                        end else begin
                            ss_ack <= 1'b1;
                            busy   <= flush_pend;
                            state  <= IDLE;
                            if (op_done) begin
                                wvalid <= 2'b00;
                            end else begin
                                wbuf   <= merge_half(wbuf, op_din, op_h);
                                wtag   <= op_q;
                                wvalid <= half_bit(op_h);
                                if (rvalid && rtag == op_q) rbuf <= merge_half(rbuf, op_din, op_h);
                            end
                        end
                    end
                end
                RMW_RD: begin
                    ch4_req  <= 1'b1;
                    ch4_rnw  <= 1'b1;
                    ch4_addr <= qaddr(wtag);
                    state    <= RMW_WAIT;
                end
                RMW_WAIT: begin
                    if (ch4_ready) begin
                        wbuf[63:32] <= wvalid[1] ? wbuf[63:32] : ch4_dout[63:32];
                        wbuf[31:0]  <= wvalid[0] ? wbuf[31:0]  : ch4_dout[31:0];
                        wvalid      <= 2'b11;
                        state       <= WR_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    ch4_req  <= 1'b1;
                    ch4_rnw  <= 1'b1;
                    ch4_addr <= qaddr(op_q);
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (ch4_ready) begin
                        rbuf    <= ch4_dout;
                        rtag    <= op_q;
                        rvalid  <= 1'b1;
                        ss_dout <= pick_half(ch4_dout, op_h);
                        ss_ack  <= 1'b1;
                        busy    <= flush_pend;
                        state   <= IDLE;
                    end
                end
                FLUSH_DONE: begin
                    ss_ack <= 1'b1;
                    busy   <= flush_pend;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_ddram_bridge.sv
// Bench for ss_ddram_bridge: directed vector table, reset/flush corner sequences, random traffic vs a dword shadow model.
module tb_ss_ddram_bridge;

    localparam logic [27:0] BASE = 28'h3C00000;
    localparam int          AW   = 22;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [AW-1:0] ss_addr = '0;
    logic [31:0]   ss_din  = '0;
    logic          ss_rnw  = 1'b0;
    logic          ss_req  = 1'b0;
    logic [31:0]   ss_dout;
    logic          ss_ack;
    logic          ss_flush = 1'b0;
    logic          busy;
    logic [26:0]   ch4_addr;
    logic [63:0]   ch4_din;
    logic [63:0]   ch4_dout;
    logic          ch4_req;
    logic          ch4_rnw;
    logic          ch4_ready;

    always #5 clk_sys = ~clk_sys;

    ss_ddram_bridge #(.BASE_ADDR(BASE), .AW(AW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .ss_addr(ss_addr), .ss_din(ss_din), .ss_rnw(ss_rnw), .ss_req(ss_req),
        .ss_dout(ss_dout), .ss_ack(ss_ack), .ss_flush(ss_flush), .busy(busy),
        .ch4_addr(ch4_addr), .ch4_din(ch4_din), .ch4_dout(ch4_dout),
        .ch4_req(ch4_req), .ch4_rnw(ch4_rnw), .ch4_ready(ch4_ready)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- DDR / arbiter model ----------------
    typedef struct {
        bit          rnw;
        logic [26:0] addr;
        logic [63:0] din;
    } txn_t;

    logic [63:0] ddr [int];
    logic [31:0] shadow [int];
    txn_t        log_q[$];
    txn_t        cur;
    bit          pend     = 1'b0;
    bit          ddr_hold = 1'b0;
    bit          stray    = 1'b0;
    int          lat_cnt  = 0;

    function automatic logic [63:0] dflt(input int q);
        return {32'hD000_0000 | 32'(q), 32'hC000_0000 | 32'(q)};
    endfunction

    function automatic logic [63:0] ddr_get(input int q);
        return ddr.exists(q) ? ddr[q] : dflt(q);
    endfunction

    function automatic int addr2q(input logic [26:0] a);
        logic [27:0] b;
        b = {a, 1'b0} - BASE;
        return int'(b >> 3);
    endfunction

    function automatic logic [31:0] exp_dword(input int a);
        logic [63:0] v;
        if (shadow.exists(a)) return shadow[a];
        v = ddr_get(a >> 1);
        return a[0] ? v[63:32] : v[31:0];
    endfunction

    initial begin
        ch4_ready = 1'b0;
        ch4_dout  = '0;
        forever begin
            @(posedge clk_sys);
            #1;
            ch4_ready = 1'b0;
            if (stray) begin
                ch4_ready = 1'b1;
                stray     = 1'b0;
            end else if (pend && !ddr_hold) begin
                if (lat_cnt > 0) begin
                    lat_cnt--;
                end else begin
                    chk("ch4_hold_addr_rnw", 64'({ch4_rnw, ch4_addr}), 64'({cur.rnw, cur.addr}));
                    if (cur.rnw) begin
                        ch4_dout = ddr_get(addr2q(cur.addr));
                    end else begin
                        chk("ch4_hold_din", ch4_din, cur.din);
                        ddr[addr2q(cur.addr)] = cur.din;
                    end
                    ch4_ready = 1'b1;
                    pend      = 1'b0;
                end
            end
            if (ch4_req) begin
                chk("ch4_single_outstanding", 64'(pend), 64'd0);
                cur.rnw  = ch4_rnw;
                cur.addr = ch4_addr;
                cur.din  = ch4_din;
                log_q.push_back(cur);
                pend    = 1'b1;
                lat_cnt = $urandom_range(0, 3);
            end
        end
    end

    // ---------------- request driver ----------------
    int          lat;
    logic [31:0] dout;

    task automatic do_op(input bit rnw, input bit fl, input bit rq, input int addr,
                         input logic [31:0] din, output int lt, output logic [31:0] dq);
        int guard;
        guard = 0;
        while (busy && guard < 200) begin
            @(posedge clk_sys);
            #1;
            guard++;
        end
        ss_req   = rq;
        ss_flush = fl;
        ss_rnw   = rnw;
        ss_addr  = AW'(addr);
        ss_din   = din;
        lt = 0;
        do begin
            @(posedge clk_sys);
            #1;
            ss_req   = 1'b0;
            ss_flush = 1'b0;
            lt++;
        end while (!ss_ack && lt < 200);
        chk("ack_seen", 64'(ss_ack), 64'd1);
        dq = ss_dout;
    endtask

    typedef struct {
        bit          rnw;
        bit          fl;
        int          addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        int          exp_ch4;
    } vec_t;

    vec_t vecs [15];
    txn_t exp_log [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, acks, cyc, first_lat, busy_bad, busy_seen;

        ddr[2] = 64'hDEADBEEF_00000000;
        ddr[3] = 64'h01234567_89ABCDEF;

        vecs[0]  = '{1'b0, 1'b0, 0, 32'h11111111, 32'h0,        0};
        vecs[1]  = '{1'b0, 1'b0, 1, 32'h22222222, 32'h0,        1};
        vecs[2]  = '{1'b0, 1'b0, 2, 32'h33333333, 32'h0,        0};
        vecs[3]  = '{1'b0, 1'b0, 3, 32'h44444444, 32'h0,        1};
        vecs[4]  = '{1'b0, 1'b0, 5, 32'hAAAA5555, 32'h0,        0};
        vecs[5]  = '{1'b0, 1'b0, 8, 32'h12345678, 32'h0,        2};
        vecs[6]  = '{1'b0, 1'b1, 0, 32'h0,        32'h0,        2};
        vecs[7]  = '{1'b1, 1'b0, 6, 32'h0,        32'h89ABCDEF, 1};
        vecs[8]  = '{1'b1, 1'b0, 7, 32'h0,        32'h01234567, 0};
        vecs[9]  = '{1'b0, 1'b0, 6, 32'hCAFEF00D, 32'h0,        0};
        vecs[10] = '{1'b1, 1'b0, 6, 32'h0,        32'hCAFEF00D, 0};
        vecs[11] = '{1'b0, 1'b1, 0, 32'h0,        32'h0,        2};
        vecs[12] = '{1'b1, 1'b0, 7, 32'h0,        32'h01234567, 0};
        vecs[13] = '{1'b1, 1'b0, 6, 32'h0,        32'hCAFEF00D, 0};
        vecs[14] = '{1'b0, 1'b1, 0, 32'h0,        32'h0,        0};

        exp_log[0] = '{1'b0, 27'h1E00000, 64'h22222222_11111111};
        exp_log[1] = '{1'b0, 27'h1E00004, 64'h44444444_33333333};
        exp_log[2] = '{1'b1, 27'h1E00008, 64'h0};
        exp_log[3] = '{1'b0, 27'h1E00008, 64'hAAAA5555_00000000};
        exp_log[4] = '{1'b1, 27'h1E00010, 64'h0};
        exp_log[5] = '{1'b0, 27'h1E00010, 64'hD0000004_12345678};
        exp_log[6] = '{1'b1, 27'h1E0000C, 64'h0};
        exp_log[7] = '{1'b1, 27'h1E0000C, 64'h0};
        exp_log[8] = '{1'b0, 27'h1E0000C, 64'h01234567_CAFEF00D};

        // reset state
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_ss_outs", 64'({ss_ack, busy, ss_dout}), 64'd0);
        chk("reset_ch4_ctl", 64'({ch4_req, ch4_rnw, ch4_addr}), 64'd0);
        chk("reset_ch4_din", ch4_din, 64'd0);
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;

        // directed vector table
        for (int i = 0; i < 15; i++) begin
            n0 = log_q.size();
            do_op(vecs[i].rnw, vecs[i].fl, !vecs[i].fl, vecs[i].addr, vecs[i].din, lat, dout);
            chk($sformatf("vec%0d_ch4_count", i), 64'(log_q.size() - n0), 64'(vecs[i].exp_ch4));
            if (vecs[i].rnw) chk($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
            if (vecs[i].exp_ch4 == 0) chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
        end
        chk("log_len", 64'(log_q.size()), 64'd9);
        for (int i = 0; i < 9 && i < log_q.size(); i++) begin
            chk($sformatf("log%0d_rnw_addr", i), 64'({log_q[i].rnw, log_q[i].addr}),
                64'({exp_log[i].rnw, exp_log[i].addr}));
            if (!exp_log[i].rnw) chk($sformatf("log%0d_din", i), log_q[i].din, exp_log[i].din);
        end

        // reset while in RD_WAIT, then a stray ch4_ready
        ddr_hold = 1'b1;
        ss_req = 1'b1; ss_rnw = 1'b1; ss_addr = AW'(40); ss_din = '0;
        @(posedge clk_sys);
        #1;
        ss_req = 1'b0;
        cyc = 0;
        while (!pend && cyc < 50) begin
            @(posedge clk_sys);
            #1;
            cyc++;
        end
        chk("rst_rd_issued", 64'(pend), 64'd1);
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b0;
        @(posedge clk_sys);
        #1;
        chk("rst_mid_outputs", 64'({busy, ss_ack, ch4_req}), 64'd0);
        reset_n  = 1'b1;
        pend     = 1'b0;
        ddr_hold = 1'b0;
        stray    = 1'b1;
        acks = 0;
        busy_seen = 0;
        repeat (6) begin
            @(posedge clk_sys);
            #1;
            if (ss_ack) acks++;
            if (busy) busy_seen++;
        end
        chk("stray_no_ack", 64'(acks), 64'd0);
        chk("stray_not_busy", 64'(busy_seen), 64'd0);
        n0 = log_q.size();
        do_op(1'b1, 1'b0, 1'b1, 40, 32'h0, lat, dout);
        chk("post_reset_fresh_req", 64'(log_q.size() - n0), 64'd1);
        chk("post_reset_dout", 64'(dout), 64'h0000_0000_C000_0014);

        // request and flush in the same cycle
        ss_req = 1'b1; ss_flush = 1'b1; ss_rnw = 1'b0; ss_addr = AW'(50); ss_din = 32'h5A5A0F0F;
        acks = 0; cyc = 0; first_lat = 0; busy_bad = 0;
        while (acks < 2 && cyc < 200) begin
            @(posedge clk_sys);
            #1;
            ss_req   = 1'b0;
            ss_flush = 1'b0;
            cyc++;
            if (ss_ack) begin
                acks++;
                if (acks == 1) begin
                    first_lat = cyc;
                    chk("rf_busy_at_req_ack", 64'(busy), 64'd1);
                end else begin
                    chk("rf_busy_after_flush_ack", 64'(busy), 64'd0);
                end
            end else if (acks == 1 && !busy) begin
                busy_bad++;
            end
        end
        chk("rf_two_acks", 64'(acks), 64'd2);
        chk("rf_req_ack_first", 64'(first_lat), 64'd1);
        chk("rf_busy_held", 64'(busy_bad), 64'd0);
        chk("rf_ddr_q25", ddr_get(25), 64'hD0000019_5A5A0F0F);

        // random traffic against a dword shadow of everything written
        for (int k = 0; k < 200; k++) begin
            int r, a;
            logic [31:0] d;
            r = $urandom_range(0, 7);
            a = 64 + $urandom_range(0, 15);
            d = $urandom;
            if (r == 0) begin
                do_op(1'b0, 1'b1, 1'b0, 0, 32'h0, lat, dout);
            end else if (r < 4) begin
                do_op(1'b0, 1'b0, 1'b1, a, d, lat, dout);
                shadow[a] = d;
            end else begin
                do_op(1'b1, 1'b0, 1'b1, a, 32'h0, lat, dout);
                chk($sformatf("rand_rd_d%0d", a), 64'(dout), 64'(exp_dword(a)));
            end
        end
        do_op(1'b0, 1'b1, 1'b0, 0, 32'h0, lat, dout);
        for (int q = 32; q < 40; q++) begin
            chk($sformatf("rand_ddr_q%0d", q), ddr_get(q), {exp_dword(2 * q + 1), exp_dword(2 * q)});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
